// File: rtl/fft_pingpong_ctrl.sv
`default_nettype none
// fft_pingpong_ctrl: two-bank ping-pong sample store and sequencer for an in-place radix-2 FFT.
// Optional macro BIT_REVERSE_LOAD_EN stores load words at the bit-reversed load_addr.
module fft_pingpong_ctrl #(
  parameter int vector_size = 16,
  parameter int N           = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              load_valid,
  input  logic [$clog2(N)-1:0]              load_addr,
  input  logic [2*vector_size-1:0]          load_data,
  input  logic                              load_last,
  input  logic [$clog2(N)-1:0]              rd_address1,
  input  logic [$clog2(N)-1:0]              rd_address2,
  output logic [2*vector_size-1:0]          samp1,
  output logic [2*vector_size-1:0]          samp2,
  input  logic                              wr_en,
  input  logic [$clog2(N)-1:0]              wr_address1,
  input  logic [$clog2(N)-1:0]              wr_address2,
  input  logic [2*vector_size-1:0]          comp1,
  input  logic [2*vector_size-1:0]          comp2,
  input  logic                              stage_done,
  input  logic [$clog2(N)-1:0]              unload_addr,
  output logic [2*vector_size-1:0]          unload_data,
  input  logic                              unload_last,
  output logic [$clog2($clog2(N)):0]        stage,
  output logic                              bank_select,
  output logic                              busy,
  output logic                              done
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = $clog2(LOG2N) + 1;
  localparam int W     = 2 * vector_size;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   stage_nxt;
  logic            bank_sel_nxt;
  logic            done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      stage       <= '0;
      bank_select <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      stage       <= stage_nxt;
      bank_select <= bank_sel_nxt;
      done        <= done_nxt;
    end
  end

  // bank_select names the bank being written; it flips on every stage boundary,
  // including the last, so in UNLOAD the result lives in ~bank_select.
  always_comb begin
    state_nxt    = state;
    stage_nxt    = stage;
    bank_sel_nxt = bank_select;
    done_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_LOAD;
          stage_nxt    = '0;
          bank_sel_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_valid && load_last) begin
          state_nxt    = S_COMPUTE;
          stage_nxt    = '0;
          bank_sel_nxt = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (stage_done) begin
          stage_nxt    = stage + SW'(1);
          bank_sel_nxt = ~bank_select;
          if (stage == LAST_STAGE) begin
            state_nxt = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        if (unload_last) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  logic             load_we;
  logic             comp_we;
  logic [LOG2N-1:0] load_waddr;

  assign load_we = !rst && (state == S_LOAD) && load_valid;
  assign comp_we = !rst && (state == S_COMPUTE) && wr_en;

`ifdef BIT_REVERSE_LOAD_EN
  always_comb begin
    load_waddr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      load_waddr[i] = load_addr[LOG2N-1-i];
    end
  end
`else
  assign load_waddr = load_addr;
`endif

  logic [W-1:0] bank0 [N];
  logic [W-1:0] bank1 [N];

  // Port 2 is written after port 1 so that comp2 wins on an address collision.
  always_ff @(posedge clk) begin
    if (load_we) begin
      bank0[load_waddr] <= load_data;
    end
    if (comp_we && !bank_select) begin
      bank0[wr_address1] <= comp1;
      bank0[wr_address2] <= comp2;
    end
  end

  always_ff @(posedge clk) begin
    if (comp_we && bank_select) begin
      bank1[wr_address1] <= comp1;
      bank1[wr_address2] <= comp2;
    end
  end

  // In COMPUTE the read bank is the one not being written; in UNLOAD it is the
  // bank written by the final stage. Both reduce to the same select.
  logic [W-1:0] rd1_word;
  logic [W-1:0] rd2_word;
  logic [W-1:0] unl_word;

  assign rd1_word = bank_select ? bank0[rd_address1] : bank1[rd_address1];
  assign rd2_word = bank_select ? bank0[rd_address2] : bank1[rd_address2];
  assign unl_word = bank_select ? bank0[unload_addr] : bank1[unload_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      samp1       <= '0;
      samp2       <= '0;
      unload_data <= '0;
    end else begin
      if (state == S_COMPUTE) begin
        samp1 <= rd1_word;
        samp2 <= rd2_word;
      end
      if (state == S_UNLOAD) begin
        unload_data <= unl_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_ctrl.sv
`default_nettype none
// tb_fft_pingpong_ctrl: randomized bench checked every cycle against a bank-level reference model,
// plus directed literal expectations. Honors BIT_REVERSE_LOAD_EN like the design.
module tb_fft_pingpong_ctrl;

  localparam int VS    = 16;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int W     = 2 * VS;
  localparam int SW    = 4;

  localparam logic [W-1:0] VAL_A   = 32'hAAAA_0001;
  localparam logic [W-1:0] VAL_B   = 32'hBBBB_0002;
  localparam logic [W-1:0] VAL_FIN = 32'hCAFE_0007;
`ifdef BIT_REVERSE_LOAD_EN
  localparam logic [W-1:0] EXP_RD5  = 32'd20;
  localparam logic [W-1:0] EXP_RD16 = 32'd1;
`else
  localparam logic [W-1:0] EXP_RD5  = 32'd5;
  localparam logic [W-1:0] EXP_RD16 = 32'd16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, load_valid, load_last, wr_en, stage_done, unload_last;
  logic [LOG2N-1:0] load_addr, rd_address1, rd_address2, wr_address1, wr_address2, unload_addr;
  logic [W-1:0]     load_data, comp1, comp2, samp1, samp2, unload_data;
  logic [SW-1:0]    stage;
  logic             bank_select, busy, done;

  fft_pingpong_ctrl #(.vector_size(VS), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .rd_address1(rd_address1), .rd_address2(rd_address2), .samp1(samp1), .samp2(samp2),
    .wr_en(wr_en), .wr_address1(wr_address1), .wr_address2(wr_address2),
    .comp1(comp1), .comp2(comp2), .stage_done(stage_done),
    .unload_addr(unload_addr), .unload_data(unload_data), .unload_last(unload_last),
    .stage(stage), .bank_select(bank_select), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 compute, 3 unload.
  // Stage s writes bank (s+1)%2 and reads bank s%2; bank_select equals "stage is even".
  logic [W-1:0] mb0 [N];
  logic [W-1:0] mb1 [N];
  int           m_ph = 0;
  int           m_stage = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_s1, m_s2, m_unl;
  bit           m_after_rst = 1'b0;

  function automatic int lmap(input int a);
    int r = 0;
`ifdef BIT_REVERSE_LOAD_EN
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((a >> b) & 1);
`else
    r = a;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] mread(input int bank, input int a);
    return (bank == 1) ? mb1[a] : mb0[a];
  endfunction

  task automatic mwrite(input int bank, input int a, input logic [W-1:0] d);
    if (bank == 1) mb1[a] = d;
    else           mb0[a] = d;
  endtask

  task automatic model_step();
    int rb;
    if (rst) begin
      m_ph = 0; m_stage = 0; m_done = 1'b0;
      m_s1 = '0; m_s2 = '0; m_unl = '0; m_after_rst = 1'b1;
      return;
    end
    m_done = 1'b0;
    case (m_ph)
      0: if (start) begin m_ph = 1; m_after_rst = 1'b0; end
      1: if (load_valid) begin
           mb0[lmap(int'(load_addr))] = load_data;
           if (load_last) begin m_ph = 2; m_stage = 0; end
         end
      2: begin
           rb   = m_stage % 2;
           m_s1 = mread(rb, int'(rd_address1));
           m_s2 = mread(rb, int'(rd_address2));
           if (wr_en) begin
             mwrite(1 - rb, int'(wr_address1), comp1);
             mwrite(1 - rb, int'(wr_address2), comp2);
           end
           if (stage_done) begin
             m_stage++;
             if (m_stage == LOG2N) m_ph = 3;
           end
         end
      default: begin
           m_unl = mread(1 - ((LOG2N - 1) % 2), int'(unload_addr));
           if (unload_last) begin m_ph = 0; m_done = 1'b1; end
         end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 64'(busy), 64'(m_ph != 0));
      cmp("done", 64'(done), 64'(m_done));
      if (m_ph >= 2 || (m_ph == 0 && m_after_rst)) begin
        cmp("stage", 64'(stage), 64'(m_stage));
        cmp("bank_select", 64'(bank_select), 64'((m_ph >= 2) ? (m_stage % 2 == 0) : 1'b0));
      end
      if (!$isunknown(m_s1))  cmp("samp1", 64'(samp1), 64'(m_s1));
      if (!$isunknown(m_s2))  cmp("samp2", 64'(samp2), 64'(m_s2));
      if (!$isunknown(m_unl)) cmp("unload_data", 64'(unload_data), 64'(m_unl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clr_rand();
    start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    wr_en = 1'b0; stage_done = 1'b0; unload_last = 1'b0;
    load_addr   = LOG2N'($urandom); load_data = $urandom;
    rd_address1 = LOG2N'($urandom); rd_address2 = LOG2N'($urandom);
    wr_address1 = LOG2N'($urandom); wr_address2 = LOG2N'($urandom);
    comp1 = $urandom; comp2 = $urandom;
    unload_addr = LOG2N'($urandom);
  endtask

  task automatic run_random(input int abort_stage);
    int perm [N];
    int idx, j, tmp;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    clr_rand(); start = 1'b1; tick();
    idx = 0;
    while (idx < N) begin
      clr_rand();
      wr_en       = 1'($urandom_range(0, 1));
      stage_done  = ($urandom_range(0, 3) == 0);
      start       = ($urandom_range(0, 3) == 0);
      unload_last = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        load_valid = 1'b1;
        load_addr  = LOG2N'(perm[idx]);
        load_last  = (idx == N - 1);
        idx++;
      end else begin
        load_last = 1'($urandom_range(0, 1));
      end
      tick();
    end
    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        repeat ($urandom_range(0, 2)) begin
          clr_rand();
          load_valid  = 1'($urandom_range(0, 1));
          unload_last = 1'($urandom_range(0, 1));
          start       = 1'($urandom_range(0, 1));
          tick();
        end
        clr_rand(); wr_en = 1'b1;
        if (k % 2 == 1) begin wr_address1 = LOG2N'(k); wr_address2 = LOG2N'(k + N / 2); end
        else            begin wr_address1 = LOG2N'(k + N / 2); wr_address2 = LOG2N'(k); end
        tick();
      end
      if (s == abort_stage) begin
        clr_rand(); wr_en = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        cmp("abort_busy",  64'(busy), 64'(0));
        cmp("abort_stage", 64'(stage), 64'(0));
        cmp("abort_bsel",  64'(bank_select), 64'(0));
        cmp("abort_samp1", 64'(samp1), 64'(0));
        cmp("abort_samp2", 64'(samp2), 64'(0));
        return;
      end
      clr_rand(); wr_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) wr_address2 = wr_address1;
      stage_done = 1'b1;
      tick();
    end
    repeat ($urandom_range(8, 24)) begin clr_rand(); tick(); end
    clr_rand(); unload_last = 1'b1; tick();
    clr_rand(); tick();
  endtask

  logic bsel_exp [LOG2N + 1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    clr_rand();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_busy",  64'(busy), 64'(0));
    cmp("rst_done",  64'(done), 64'(0));
    cmp("rst_stage", 64'(stage), 64'(0));
    cmp("rst_bsel",  64'(bank_select), 64'(0));
    cmp("rst_samp1", 64'(samp1), 64'(0));
    cmp("rst_unload_data", 64'(unload_data), 64'(0));
    rst = 1'b0;

    clr_rand(); stage_done = 1'b1; wr_en = 1'b1; tick();
    cmp("idle_stage_done_busy",  64'(busy), 64'(0));
    cmp("idle_stage_done_stage", 64'(stage), 64'(0));

    clr_rand(); start = 1'b1; tick();
    cmp("start_busy", 64'(busy), 64'(1));
    for (int i = 0; i < N; i++) begin
      clr_rand();
      load_valid = 1'b1; load_addr = LOG2N'(i); load_data = W'(i); load_last = (i == N - 1);
      tick();
    end
    cmp("compute_entry_stage", 64'(stage), 64'(0));
    cmp("compute_entry_bsel",  64'(bank_select), 64'(1));
    cmp("compute_entry_busy",  64'(busy), 64'(1));

    clr_rand(); rd_address1 = 5'd5; rd_address2 = 5'd16; tick();
    cmp("read_addr5",  64'(samp1), 64'(EXP_RD5));
    cmp("read_addr16", 64'(samp2), 64'(EXP_RD16));

    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        clr_rand(); wr_en = 1'b1;
        wr_address1 = LOG2N'(k); wr_address2 = LOG2N'(k + N / 2);
        if (s == 1 && k == 0) rd_address1 = 5'd3;
        if (s == 1 && k == 3) start = 1'b1;
        tick();
        if (s == 1 && k == 0) cmp("equal_addr_comp2_wins", 64'(samp1), 64'(VAL_B));
        if (s == 1 && k == 3) begin
          cmp("start_in_compute_busy",  64'(busy), 64'(1));
          cmp("start_in_compute_stage", 64'(stage), 64'(1));
        end
      end
      clr_rand(); wr_en = 1'b1; stage_done = 1'b1;
      if (s == 0) begin
        wr_address1 = 5'd3; wr_address2 = 5'd3; comp1 = VAL_A; comp2 = VAL_B;
      end
      if (s == LOG2N - 1) begin
        wr_address1 = 5'd7; wr_address2 = 5'd7; comp2 = VAL_FIN;
      end
      tick();
      cmp("stage_after_done", 64'(stage), 64'(s + 1));
      cmp("bsel_after_done",  64'(bank_select), 64'(bsel_exp[s + 1]));
      cmp("busy_after_done",  64'(busy), 64'(1));
    end

    for (int k = 0; k < N; k++) begin
      clr_rand(); unload_addr = LOG2N'(k); tick();
      if (k == 7) cmp("unload_final_word", 64'(unload_data), 64'(VAL_FIN));
    end
    clr_rand(); unload_last = 1'b1; tick();
    cmp("done_pulse", 64'(done), 64'(1));
    cmp("done_busy",  64'(busy), 64'(0));
    clr_rand(); tick();
    cmp("done_clears", 64'(done), 64'(0));

    clr_rand(); rst = 1'b1; start = 1'b1; tick();
    cmp("rst_over_start_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    run_random(2);
    run_random(-1);
    run_random(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_pingpong_ctrl.md
FFT_PINGPONG_CTRL -- requirements
Module: fft_pingpong_ctrl

Interface
REQ-001 SHALL take parameter vector_size, default 16, meaning bits per real/imag component; a word is 2*vector_size bits.
REQ-002 SHALL take parameter N, default 32, meaning FFT points and words per bank; power of two, >=4; log2N = $clog2(N); SW = $clog2(log2N)+1.
REQ-003 SHALL have clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have start  input  1  begin a transform when idle.
REQ-006 SHALL have load_valid  input  1  load word strobe.
REQ-007 SHALL have load_addr  input  log2N  load index.
REQ-008 SHALL have load_data  input  2*vector_size  load word.
REQ-009 SHALL have load_last  input  1  final load word, qualified by load_valid.
REQ-010 SHALL have rd_address1, rd_address2  input  log2N each  butterfly read addresses.
REQ-011 SHALL have samp1, samp2  output  2*vector_size each  registered read data.
REQ-012 SHALL have wr_en  input  1  butterfly write strobe.
REQ-013 SHALL have wr_address1, wr_address2  input  log2N each  butterfly write addresses.
REQ-014 SHALL have comp1, comp2  input  2*vector_size each  butterfly results.
REQ-015 SHALL have stage_done  input  1  pulse ending the current stage.
REQ-016 SHALL have unload_addr  input  log2N  result read index; unload_data  output  2*vector_size  registered result word; unload_last  input  1  ends unload.
REQ-017 SHALL have stage  output  SW  current stage; bank_select  output  1  write bank; busy  output  1; done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL contain two banks (bank0, bank1), each N words, two write and two read ports.
REQ-019 SHALL implement FSM IDLE->LOAD (start) ->COMPUTE (load_valid&load_last) ->UNLOAD (stage_done while stage==log2N-1) ->IDLE (unload_last); start ignored outside IDLE.
REQ-020 SHALL, in LOAD, write load_data to bank0[load_addr] on load_valid; all other write inputs ignored.
REQ-021 SHALL, in COMPUTE, write bank selected by bank_select and read the other; bank_select=1 at COMPUTE entry (stage 0 reads bank0, writes bank1).
REQ-022 SHALL, on wr_en in COMPUTE, write comp1 to wr_address1 and comp2 to wr_address2 of the write bank; if addresses equal, comp2 wins.
REQ-023 SHALL present samp1/samp2 one cycle after rd_address1/2 (latency 1); a same-cycle write to the read bank cannot occur.
REQ-024 SHALL, on stage_done in COMPUTE, toggle bank_select and increment stage; wr_en in that cycle still commits to the pre-toggle bank.
REQ-025 SHALL, in UNLOAD, read the bank last written (bank_select at final stage_done) at unload_addr, unload_data valid one cycle later.
REQ-026 SHALL assert busy in LOAD, COMPUTE, UNLOAD; pulse done for one cycle on UNLOAD->IDLE.
REQ-027 SHALL ignore wr_en, stage_done outside COMPUTE and load_valid outside LOAD.
REQ-028 SHALL hold samp1, samp2, unload_data when not read-addressed states (IDLE/LOAD retain last value).

Reset
REQ-029 SHALL on rst force IDLE, stage=0, bank_select=0, busy=0, done=0, samp1=samp2=unload_data=0; bank contents undefined.
REQ-030 SHALL, when rst asserts mid-transform, abort immediately; rst overrides start in the same cycle.

Configuration
REQ-031 SHALL, with macro BIT_REVERSE_LOAD_EN defined, write load data at bit-reversed load_addr (log2N bits); without it, at load_addr unchanged.

Verification
REQ-032 SHALL: N=32, rst then start, load 0..31 with data=index, load_last at 31 -> state COMPUTE, bank_select=1, stage=0, busy=1.
REQ-033 SHALL: in COMPUTE rd_address1=5 -> samp1=5 one cycle later; wr_en with wr_address1=wr_address2=3, comp1=A, comp2=B -> later read of 3 returns B.
REQ-034 SHALL: five stage_done pulses with wr_en on each -> stage 0..4, bank_select toggles each, fifth enters UNLOAD; unload_addr=k returns final-stage word, unload_last -> done=1 for one cycle, busy=0.
REQ-035 SHALL: rst asserted mid-COMPUTE at stage 2 -> next cycle IDLE, stage=0, bank_select=0, samp1=0.
REQ-036 SHALL: BIT_REVERSE_LOAD_EN defined, load_addr=1 data=X -> X appears at bank0 address 16 (N=32); undefined -> at address 1.
REQ-037 SHALL: start pulsed during COMPUTE, stage_done pulsed in IDLE -> no state or stage change.
